couche_substitution_inverse_iter: RTL and testbench

- Iterative inverse of the ASCON substitution layer p_s. Applies the inverse 5-bit S-box to every one of the 64 columns of a type_state.
- Processes COLS_PER_CYCLE columns per clock and uses valid/ready handshakes on both sides.
- Sits in the decryption/verification datapath. Inverts the forward combinational substitution layer, trading area for latency.

---
 rtl/couche_substitution_inverse_iter.sv | 133 +++++++++++++
 tb/tb_couche_substitution_inverse_iter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/couche_substitution_inverse_iter.sv
// Iterative inverse of the ASCON substitution layer: applies the inverse 5-bit
// S-box to COLS_PER_CYCLE columns of the 5x64 state per clock, valid/ready on both sides.
module couche_substitution_inverse_iter #(
    parameter int COLS_PER_CYCLE = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [4:0][63:0] state_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [4:0][63:0] state_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o
);

    localparam int NUM_STEPS = 64 / COLS_PER_CYCLE;
    localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_STEPS - 1);

    if (!(COLS_PER_CYCLE == 1  || COLS_PER_CYCLE == 2  || COLS_PER_CYCLE == 4 ||
          COLS_PER_CYCLE == 8  || COLS_PER_CYCLE == 16 || COLS_PER_CYCLE == 32 ||
          COLS_PER_CYCLE == 64)) begin : g_bad_cols_per_cycle
        $error("COLS_PER_CYCLE must be one of 1, 2, 4, 8, 16, 32, 64");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

    // Inverse of the ASCON forward S-box; column value has row 0 as MSB.
    function automatic logic [4:0] sbox_inv(input logic [4:0] v);
        case (v)
            5'h00: sbox_inv = 5'h14;  5'h01: sbox_inv = 5'h1a;
            5'h02: sbox_inv = 5'h07;  5'h03: sbox_inv = 5'h0d;
            5'h04: sbox_inv = 5'h00;  5'h05: sbox_inv = 5'h09;
            5'h06: sbox_inv = 5'h0e;  5'h07: sbox_inv = 5'h12;
            5'h08: sbox_inv = 5'h0a;  5'h09: sbox_inv = 5'h06;
            5'h0a: sbox_inv = 5'h1d;  5'h0b: sbox_inv = 5'h01;
            5'h0c: sbox_inv = 5'h19;  5'h0d: sbox_inv = 5'h15;
            5'h0e: sbox_inv = 5'h13;  5'h0f: sbox_inv = 5'h1e;
            5'h10: sbox_inv = 5'h18;  5'h11: sbox_inv = 5'h16;
            5'h12: sbox_inv = 5'h0b;  5'h13: sbox_inv = 5'h11;
            5'h14: sbox_inv = 5'h03;  5'h15: sbox_inv = 5'h05;
            5'h16: sbox_inv = 5'h1c;  5'h17: sbox_inv = 5'h1f;
            5'h18: sbox_inv = 5'h17;  5'h19: sbox_inv = 5'h1b;
            5'h1a: sbox_inv = 5'h04;  5'h1b: sbox_inv = 5'h08;
            5'h1c: sbox_inv = 5'h0f;  5'h1d: sbox_inv = 5'h0c;
            5'h1e: sbox_inv = 5'h10;  5'h1f: sbox_inv = 5'h02;
            default: sbox_inv = 5'h00;
        endcase
    endfunction

    fsm_state_t       fsm_r;
    logic [CNT_W-1:0] cnt_r;
    logic [4:0][63:0] work_r;
    logic [4:0][63:0] work_next_s;

    // Substitute the column group selected by the counter; other columns hold.
    always_comb begin
        logic [4:0] col_v;
        work_next_s = work_r;
        col_v       = 5'h00;
        for (int i = 0; i < 64; i++) begin
            if (CNT_W'(i / COLS_PER_CYCLE) == cnt_r) begin
                col_v = sbox_inv({work_r[0][i], work_r[1][i], work_r[2][i],
                                  work_r[3][i], work_r[4][i]});
                for (int r = 0; r < 5; r++) begin
                    work_next_s[r][i] = col_v[4-r];
                end
            end else begin
                for (int r = 0; r < 5; r++) begin
                    work_next_s[r][i] = work_r[r][i];
                end
            end
        end
    end

    // Control FSM, working register and registered handshake/data outputs.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_r   <= ST_IDLE;
            cnt_r   <= '0;
            work_r  <= '0;
            state_o <= '0;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    if (valid_i) begin
                        work_r  <= state_i;
                        cnt_r   <= '0;
                        fsm_r   <= ST_RUN;
                        ready_o <= 1'b0;
                        busy_o  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    work_r <= work_next_s;
                    if (cnt_r == LAST_CNT) begin
                        cnt_r   <= '0;
                        fsm_r   <= ST_DONE;
                        busy_o  <= 1'b0;
                        valid_o <= 1'b1;
                        state_o <= work_next_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // A valid_i seen here is left for the IDLE state to accept.
                    if (ready_i) begin
                        fsm_r   <= ST_IDLE;
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                    end
                end
                default: begin
                    fsm_r   <= ST_IDLE;
                    cnt_r   <= '0;
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_couche_substitution_inverse_iter.sv
// Self-checking bench: three instances (1, 8 and 64 columns per cycle) checked
// against constant vectors and a forward-S-box round-trip reference.
module tb_couche_substitution_inverse_iter;

    localparam logic [63:0] ZR   = 64'h0000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] LSB0 = 64'hFFFF_FFFF_FFFF_FFFE;

    localparam logic [4:0] FWD [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    logic             clk;
    logic             rst    [3];
    logic [4:0][63:0] st_in  [3];
    logic [4:0][63:0] st_out [3];
    logic             vin    [3];
    logic             vout   [3];
    logic             rdy_in [3];
    logic             rdy_out[3];
    logic             busy   [3];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NG = (g == 0) ? 1 : ((g == 1) ? 8 : 64);
        couche_substitution_inverse_iter #(.COLS_PER_CYCLE(NG)) dut (
            .clock_i(clk),
            .reset_i(rst[g]),
            .state_i(st_in[g]),
            .valid_i(vin[g]),
            .ready_o(rdy_out[g]),
            .state_o(st_out[g]),
            .valid_o(vout[g]),
            .ready_i(rdy_in[g]),
            .busy_o(busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic int cols_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 8 : 64);
    endfunction

    function automatic logic [4:0][63:0] mk(input logic [63:0] r0, r1, r2, r3, r4);
        logic [4:0][63:0] s;
        s[0] = r0; s[1] = r1; s[2] = r2; s[3] = r3; s[4] = r4;
        return s;
    endfunction

    // Reference forward layer: the block under test must undo it exactly.
    function automatic logic [4:0][63:0] fwd_layer(input logic [4:0][63:0] x);
        logic [4:0][63:0] y;
        logic [4:0]       c;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            c = {x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]};
            c = FWD[c];
            for (int r = 0; r < 5; r++) y[r][i] = c[4-r];
        end
        return y;
    endfunction

    function automatic logic [4:0][63:0] rand_state();
        logic [4:0][63:0] s;
        for (int r = 0; r < 5; r++) s[r] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // One transaction from IDLE with ready_i=1; returns output, latency in edges
    // and whether ready_o stayed low from accept until valid_o.
    task automatic run_txn(input int k, input logic [4:0][63:0] x,
                           output logic [4:0][63:0] y, output int lat, output logic rdy_low);
        st_in[k]  = x;
        vin[k]    = 1'b1;
        rdy_in[k] = 1'b1;
        @(negedge clk);
        vin[k]  = 1'b0;
        lat     = 1;
        rdy_low = 1'b1;
        while (vout[k] !== 1'b1 && lat < 200) begin
            if (rdy_out[k] !== 1'b0) rdy_low = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (rdy_out[k] !== 1'b0) rdy_low = 1'b0;
        y = st_out[k];
        @(negedge clk);
    endtask

    task automatic round_trip(input int k, input int count);
        logic [4:0][63:0] x, y;
        int   lat;
        logic rl;
        for (int j = 0; j < count; j++) begin
            x = rand_state();
            run_txn(k, fwd_layer(x), y, lat, rl);
            check($sformatf("roundtrip_n%0d_state_%0d", cols_of(k), j), y, x);
            check($sformatf("roundtrip_n%0d_latency_%0d", cols_of(k), j),
                  320'(lat), 320'(64 / cols_of(k) + 1));
        end
    endtask

    typedef struct {
        logic [4:0][63:0] st;
        logic [4:0][63:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [4:0][63:0] x, y, cap;
        logic [4:0][63:0] xs[4];
        int   lat, w, acc, prev_acc;
        logic rl, stable;

        vecs[0] = '{st: mk(ZR, ZR, ZR, ZR, ZR),             exp: mk(ONES, ZR, ONES, ZR, ZR)};
        vecs[1] = '{st: mk(LSB0, LSB0, ONES, LSB0, LSB0),   exp: mk(ZR, ZR, ZR, LSB0, ZR)};
        vecs[2] = '{st: mk(ONES, ONES, ONES, ONES, ONES),   exp: mk(ZR, ZR, ZR, ONES, ZR)};
        vecs[3] = '{st: mk(ZR, ONES, ZR, ONES, ONES),       exp: mk(ZR, ZR, ZR, ZR, ONES)};
        vecs[4] = '{st: mk(ZR, ZR, ONES, ZR, ZR),           exp: mk(ZR, ZR, ZR, ZR, ZR)};

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; vin[k] = 1'b0; rdy_in[k] = 1'b1; st_in[k] = '0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_ready_n%0d", cols_of(k)), 320'(rdy_out[k]), 320'(1));
            check($sformatf("reset_valid_n%0d", cols_of(k)), 320'(vout[k]), 320'(0));
            check($sformatf("reset_busy_n%0d", cols_of(k)), 320'(busy[k]), 320'(0));
            check($sformatf("reset_state_n%0d", cols_of(k)), st_out[k], 320'(0));
            rst[k] = 1'b0;
        end
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            run_txn(1, vecs[v].st, y, lat, rl);
            check($sformatf("vector_%0d_state", v), y, vecs[v].exp);
            check($sformatf("vector_%0d_latency", v), 320'(lat), 320'(9));
            check($sformatf("vector_%0d_ready_low", v), 320'(rl), 320'(1));
        end

        // Backpressure: hold ready_i low for 20 cycles after valid_o rises.
        x = rand_state();
        st_in[1] = fwd_layer(x); vin[1] = 1'b1; rdy_in[1] = 1'b0;
        @(negedge clk);
        vin[1] = 1'b0; lat = 1;
        while (vout[1] !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
        check("bp_latency", 320'(lat), 320'(9));
        check("bp_state", st_out[1], x);
        cap = st_out[1]; stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (vout[1] !== 1'b1 || st_out[1] !== cap || rdy_out[1] !== 1'b0) stable = 1'b0;
        end
        check("bp_hold_stable", 320'(stable), 320'(1));
        rdy_in[1] = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 320'(vout[1]), 320'(0));
        check("bp_release_ready", 320'(rdy_out[1]), 320'(1));

        // Asynchronous reset while the counter sits at 3.
        x = rand_state();
        st_in[1] = fwd_layer(x); vin[1] = 1'b1;
        @(negedge clk);
        vin[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst[1] = 1'b1;
        #1;
        check("midreset_valid", 320'(vout[1]), 320'(0));
        check("midreset_ready", 320'(rdy_out[1]), 320'(1));
        check("midreset_busy", 320'(busy[1]), 320'(0));
        check("midreset_state", st_out[1], 320'(0));
        @(negedge clk);
        rst[1] = 1'b0;
        @(negedge clk);
        x = rand_state();
        run_txn(1, fwd_layer(x), y, lat, rl);
        check("after_reset_state", y, x);
        check("after_reset_latency", 320'(lat), 320'(9));

        // valid_i held high: back-to-back transactions every 10 edges.
        for (int j = 0; j < 4; j++) xs[j] = rand_state();
        vin[1] = 1'b1; rdy_in[1] = 1'b1; prev_acc = 0;
        for (int j = 0; j < 4; j++) begin
            st_in[1] = fwd_layer(xs[j]);
            w = 0;
            while (rdy_out[1] !== 1'b1 && w < 100) begin @(negedge clk); w++; end
            acc = cyc;
            if (j > 0) check($sformatf("cont_interval_%0d", j), 320'(acc - prev_acc), 320'(10));
            prev_acc = acc;
            @(negedge clk);
            w = 0;
            while (vout[1] !== 1'b1 && w < 200) begin @(negedge clk); w++; end
            check($sformatf("cont_state_%0d", j), st_out[1], xs[j]);
        end
        vin[1] = 1'b0;
        @(negedge clk);
        check("cont_end_ready", 320'(rdy_out[1]), 320'(1));

        fork
            round_trip(0, 300);
            round_trip(1, 1000);
            round_trip(2, 1000);
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
